// File: rtl/booth_pp_generator_pkg.sv
// Shared types and helpers for the radix-4 Booth partial-product generator.
package booth_pp_generator_pkg;

  // Radix-4 Booth digit values.
  typedef enum logic [2:0] {
    Zero,
    Pos1,
    Pos2,
    Neg1,
    Neg2
  } booth_digit_e;

  localparam int unsigned DefaultBits = 8;

  // Number of partial-product rows for a given operand width.
  function automatic int unsigned pp_count(input int unsigned bits);
    return bits / 2;
  endfunction

  // Map a multiplier triplet {b[2i+1], b[2i], b[2i-1]} to its Booth digit.
  function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
    booth_digit_e digit;
    case (triplet)
      3'b000, 3'b111: digit = Zero;  // 111 is plain zero, never negative zero
      3'b001, 3'b010: digit = Pos1;
      3'b011:         digit = Pos2;
      3'b100:         digit = Neg2;
      default:        digit = Neg1;  // 101, 110
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_pp_generator_if.sv
// Operand-in / partial-product-out bus of the Booth generator.
interface booth_pp_generator_if
  import booth_pp_generator_pkg::*;
#(
  parameter int unsigned BITS  = DefaultBits,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned PpCount = pp_count(BITS);

  logic                in_valid;
  logic                in_ready;
  logic [BITS-1:0]     multiplicand;
  logic [BITS-1:0]     multiplier;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [BITS:0]       partial_product [PpCount];
  logic [PpCount-1:0]  negs;
  logic [TAG_W-1:0]    out_tag;

  // Producer of operands / consumer of rows.
  modport master (
    output in_valid, multiplicand, multiplier, in_tag, out_ready,
    input  in_ready, out_valid, partial_product, negs, out_tag
  );

  // The generator itself.
  modport slave (
    input  in_valid, multiplicand, multiplier, in_tag, out_ready,
    output in_ready, out_valid, partial_product, negs, out_tag
  );

endinterface

// File: rtl/booth_pp_generator_digit_encoder.sv
// Combinational radix-4 Booth row encoder for one multiplier triplet.
module booth_pp_generator_digit_encoder
  import booth_pp_generator_pkg::*;
#(
  parameter int unsigned BITS = DefaultBits
) (
  input  logic [2:0]      triplet,
  input  logic [BITS-1:0] multiplicand,
  output logic [BITS:0]   row,
  output logic            neg
);

  booth_digit_e digit;
  logic [BITS:0] sext_a;
  logic [BITS:0] dbl_a;

  assign digit  = booth_decode(triplet);
  assign sext_a = {multiplicand[BITS-1], multiplicand};
  // BITS+1 bits hold 2a exactly, including a = -2^(BITS-1).
  assign dbl_a  = {multiplicand, 1'b0};

  // Select the row; negative digits emit the ones' complement plus a neg bit.
  always_comb begin
    row = '0;
    neg = 1'b0;
    unique case (digit)
      Zero: row = '0;
      Pos1: row = sext_a;
      Pos2: row = dbl_a;
      Neg1: begin
        row = ~sext_a;
        neg = 1'b1;
      end
      Neg2: begin
        row = ~dbl_a;
        neg = 1'b1;
      end
      default: row = '0;
    endcase
  end

endmodule

// File: rtl/booth_pp_generator.sv
// Two-stage valid/ready pipeline producing radix-4 Booth partial-product rows.
module booth_pp_generator
  import booth_pp_generator_pkg::*;
#(
  parameter int unsigned BITS  = DefaultBits,
  parameter int unsigned TAG_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  booth_pp_generator_if.slave  bus
);

  localparam int unsigned PpCount = pp_count(BITS);

  // Stage A: raw operands.
  logic             valid_a_q;
  logic [BITS-1:0]  a_q;
  logic [BITS-1:0]  b_q;
  logic [TAG_W-1:0] tag_a_q;

  // Stage B: encoded rows.
  logic               valid_b_q;
  logic [BITS:0]      rows_q [PpCount];
  logic [PpCount-1:0] negs_q;
  logic [TAG_W-1:0]   tag_b_q;

  logic [BITS:0]      rows_d [PpCount];
  logic [PpCount-1:0] negs_d;
  logic [BITS:0]      b_ext;
  logic               ready_b;
  logic               ready_a;

  assign ready_b = !valid_b_q || bus.out_ready;
  assign ready_a = !valid_a_q || ready_b;
  // b[-1] = 0 appended below the LSB so every triplet is a plain slice.
  assign b_ext   = {b_q, 1'b0};

  for (genvar i = 0; i < PpCount; i++) begin : g_digit
    booth_pp_generator_digit_encoder #(
      .BITS(BITS)
    ) u_enc (
      .triplet     (b_ext[2*i+2 : 2*i]),
      .multiplicand(a_q),
      .row         (rows_d[i]),
      .neg         (negs_d[i])
    );
    assign bus.partial_product[i] = rows_q[i];
  end

  // Advance both stages; each stage loads only when its downstream can take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_a_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      tag_a_q   <= '0;
      valid_b_q <= 1'b0;
      negs_q    <= '0;
      tag_b_q   <= '0;
      for (int i = 0; i < PpCount; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      if (ready_b) begin
        valid_b_q <= valid_a_q;
        if (valid_a_q) begin
          negs_q  <= negs_d;
          tag_b_q <= tag_a_q;
          for (int i = 0; i < PpCount; i++) begin
            rows_q[i] <= rows_d[i];
          end
        end
      end
      if (ready_a) begin
        valid_a_q <= bus.in_valid;
        if (bus.in_valid) begin
          a_q     <= bus.multiplicand;
          b_q     <= bus.multiplier;
          tag_a_q <= bus.in_tag;
        end
      end
    end
  end

  assign bus.in_ready  = ready_a;
  assign bus.out_valid = valid_b_q;
  assign bus.negs      = negs_q;
  assign bus.out_tag   = tag_b_q;

endmodule

// File: tb/tb_booth_pp_generator.sv
// Self-checking bench for booth_pp_generator: directed table, backpressure, reset, random.
module tb_booth_pp_generator;

  localparam int unsigned B = 8;
  localparam int unsigned T = 4;
  localparam int unsigned P = B / 2;

  typedef struct {
    logic [B-1:0] a;
    logic [B-1:0] b;
    logic [T-1:0] tag;
    logic [B:0]   rows [P];
    logic [P-1:0] negs;
    int           sum;
  } vec_t;

  typedef struct {
    logic [B-1:0] a;
    logic [B-1:0] b;
    logic [T-1:0] tag;
  } pair_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   mon_en;
  int   n_in;
  int   n_out;
  pair_t sb_q[$];

  booth_pp_generator_if #(.BITS(B), .TAG_W(T)) bus ();

  booth_pp_generator #(
    .BITS (B),
    .TAG_W(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Booth digit for row i from the arithmetic definition -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic int model_digit(input logic [B-1:0] b, input int i);
    int lo;
    lo = (i == 0) ? 0 : int'(b[2*i-1]);
    return -2 * int'(b[2*i+1]) + int'(b[2*i]) + lo;
  endfunction

  function automatic logic [B:0] model_row(input logic [B-1:0] a, input logic [B-1:0] b,
                                           input int i);
    int d;
    int m;
    logic [B:0] r;
    d = model_digit(b, i);
    m = (d < 0 ? -d : d) * int'($signed(a));
    r = m[B:0];
    return (d < 0) ? ~r : r;
  endfunction

  // Compressor view: sum of sext(row_i) + neg_i, weighted by 4^i.
  function automatic int pp_sum(input logic [B:0] rows [P], input logic [P-1:0] negs);
    int s;
    s = 0;
    for (int i = 0; i < P; i++) begin
      s += (int'($signed(rows[i])) + int'(negs[i])) * (1 << (2 * i));
    end
    return s;
  endfunction

  function automatic bit rows_zero();
    bit z;
    z = 1'b1;
    for (int i = 0; i < P; i++) if (bus.partial_product[i] != '0) z = 1'b0;
    return z;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepts, check every emitted row set, check stability under stall.
  bit           prev_stall;
  logic [B:0]   prev_rows [P];
  logic [P-1:0] prev_negs;
  logic [T-1:0] prev_tag;
  pair_t        exp_p;
  logic [B:0]   cur_rows [P];
  bit           same;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else if (mon_en) begin
      for (int i = 0; i < P; i++) cur_rows[i] = bus.partial_product[i];
      if (prev_stall) begin
        same = bus.out_valid && (bus.negs == prev_negs) && (bus.out_tag == prev_tag);
        for (int i = 0; i < P; i++) if (cur_rows[i] != prev_rows[i]) same = 1'b0;
        chk("stall_stable", same, bus.out_tag, prev_tag);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1'b0, bus.out_tag, -1);
        end else begin
          exp_p = sb_q.pop_front();
          n_out++;
          for (int i = 0; i < P; i++) begin
            chk($sformatf("row%0d a=%0h b=%0h", i, exp_p.a, exp_p.b),
                cur_rows[i] == model_row(exp_p.a, exp_p.b, i), cur_rows[i],
                model_row(exp_p.a, exp_p.b, i));
          end
          for (int i = 0; i < P; i++) begin
            chk($sformatf("neg%0d a=%0h b=%0h", i, exp_p.a, exp_p.b),
                bus.negs[i] == (model_digit(exp_p.b, i) < 0), bus.negs[i],
                model_digit(exp_p.b, i) < 0);
          end
          chk("tag_order", bus.out_tag == exp_p.tag, bus.out_tag, exp_p.tag);
          chk($sformatf("product a=%0h b=%0h", exp_p.a, exp_p.b),
              pp_sum(cur_rows, bus.negs) == int'($signed(exp_p.a)) * int'($signed(exp_p.b)),
              pp_sum(cur_rows, bus.negs), int'($signed(exp_p.a)) * int'($signed(exp_p.b)));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back('{a: bus.multiplicand, b: bus.multiplier, tag: bus.in_tag});
        n_in++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_rows  = cur_rows;
      prev_negs  = bus.negs;
      prev_tag   = bus.out_tag;
    end
  end

  task automatic drive(input logic [B-1:0] a, input logic [B-1:0] b, input logic [T-1:0] tag);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.in_tag       = tag;
  endtask

  // Present one pair until accepted, bounded.
  task automatic send_one(input logic [B-1:0] a, input logic [B-1:0] b, input logic [T-1:0] tag);
    bit took;
    took = 1'b0;
    drive(a, b, tag);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20 && !took; c++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!took) chk("send_timeout", 1'b0, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 50 && !idle; c++) begin
      @(negedge clk);
      idle = (sb_q.size() == 0) && !bus.out_valid;
    end
    chk(name, idle, sb_q.size(), 0);
    tick();
  endtask

  vec_t  vecs [4];
  pair_t bp [3];
  vec_t  v;
  logic [B:0] got_rows [P];
  int    idx;
  bit    took;
  int    sent;
  int    in0;
  int    out0;
  logic [B-1:0] corner [4];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got simulation stuck, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_in     = 0;
    n_out    = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, '0, '0);

    vecs[0] = '{a: 8'd3, b: 8'd5, tag: 4'd1, rows: '{9'h003, 9'h003, 9'h000, 9'h000},
                negs: 4'b0000, sum: 15};
    vecs[1] = '{a: 8'hFF, b: 8'h80, tag: 4'd2, rows: '{9'h000, 9'h000, 9'h000, 9'h001},
                negs: 4'b1000, sum: 128};
    vecs[2] = '{a: 8'h80, b: 8'h80, tag: 4'd3, rows: '{9'h000, 9'h000, 9'h000, 9'h0FF},
                negs: 4'b1000, sum: 16384};
    vecs[3] = '{a: 8'd2, b: 8'h7F, tag: 4'd4, rows: '{9'h1FD, 9'h000, 9'h000, 9'h004},
                negs: 4'b0001, sum: 254};

    // Reset state.
    tick();
    tick();
    @(negedge clk);
    chk("reset_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
    chk("reset_rows", rows_zero(), 0, 0);
    chk("reset_negs", bus.negs == '0, bus.negs, 0);
    chk("reset_tag", bus.out_tag == '0, bus.out_tag, 0);
    chk("reset_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed table with latency check.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = vecs[k];
      drive(v.a, v.b, v.tag);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", k), bus.in_ready == 1'b1, bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d not_early", k), bus.out_valid == 1'b0, bus.out_valid, 0);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", k), bus.out_valid == 1'b1, bus.out_valid, 1);
      for (int i = 0; i < P; i++) begin
        got_rows[i] = bus.partial_product[i];
        chk($sformatf("vec%0d row%0d", k, i), got_rows[i] == v.rows[i], got_rows[i], v.rows[i]);
      end
      chk($sformatf("vec%0d negs", k), bus.negs == v.negs, bus.negs, v.negs);
      chk($sformatf("vec%0d tag", k), bus.out_tag == v.tag, bus.out_tag, v.tag);
      chk($sformatf("vec%0d sum", k), pp_sum(got_rows, bus.negs) == v.sum,
          pp_sum(got_rows, bus.negs), v.sum);
      tick();
    end
    wait_idle("table_drain");

    // Backpressure: three pairs offered with out_ready low for four cycles.
    for (int k = 0; k < 3; k++) bp[k] = '{a: 8'(10 + k), b: 8'(8'hF0 + k), tag: 4'(5 + k)};
    bus.out_ready = 1'b0;
    idx = 0;
    drive(bp[0].a, bp[0].b, bp[0].tag);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      tick();
      if (took) begin
        idx++;
        if (idx < 3) drive(bp[idx].a, bp[idx].b, bp[idx].tag);
      end
    end
    chk("bp_accepted", idx == 2, idx, 2);
    @(negedge clk);
    chk("bp_in_ready_low", bus.in_ready == 1'b0, bus.in_ready, 0);
    chk("bp_head_tag", bus.out_valid && bus.out_tag == bp[0].tag, bus.out_tag, bp[0].tag);
    bus.out_ready = 1'b1;
    took = 1'b0;
    for (int c = 0; c < 10 && !took; c++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      tick();
    end
    chk("bp_third_accepted", took, took, 1);
    bus.in_valid = 1'b0;
    wait_idle("bp_drain");

    // Reset with two pairs in flight.
    bus.out_ready = 1'b0;
    send_one(8'h11, 8'h22, 4'hA);
    send_one(8'h33, 8'h44, 4'hB);
    chk("rst_pre_full", bus.out_valid == 1'b1, bus.out_valid, 1);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_async_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
    chk("rst_async_rows", rows_zero(), 0, 0);
    chk("rst_async_negs", bus.negs == '0, bus.negs, 0);
    chk("rst_async_tag", bus.out_tag == '0, bus.out_tag, 0);
    @(negedge clk);
    tick();
    rst           = 1'b0;
    mon_en        = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_stale", bus.out_valid == 1'b0, bus.out_valid, 0);
    end
    tick();

    // Random traffic with random backpressure.
    corner[0] = 8'h80;
    corner[1] = 8'h7F;
    corner[2] = 8'hFF;
    corner[3] = 8'h00;
    in0  = n_in;
    out0 = n_out;
    sent = 0;
    took = 1'b1;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      if (took) begin
        drive(($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom),
              ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom),
              4'($urandom));
      end
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) sent++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("rand_sent", sent == 1000, sent, 1000);
    wait_idle("rand_drain");
    chk("rand_in_count", (n_in - in0) == 1000, n_in - in0, 1000);
    chk("rand_out_count", (n_out - out0) == 1000, n_out - out0, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
